muldiv_hilo_ctrl: RTL and testbench

- Sequences the iterative WIDTH-bit multiplier on behalf of the pipeline's execute stage.
- Decodes MULT/MULTU/MFHI/MFLO/MTHI/MTLO, launches the multiplier, and owns the HI/LO architectural registers.
- Stalls the pipeline on HI/LO hazards.
- Handles flush of an in-flight multiply and a watchdog timeout.
- Sits between the ID/EX pipeline register and the multiplier instance.

---
 rtl/muldiv_hilo_ctrl.sv | 112 +++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: sequences an iterative multiplier for the execute stage and owns HI/LO.
module muldiv_hilo_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  input  logic [2:0]         op_code,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  input  logic               flush,
  output logic               stall,
  output logic [WIDTH-1:0]   rd_data,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               timeout_err,
  output logic               mul_start,
  output logic               mul_signed,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_ready,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_p
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DRAIN} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
  logic signed_q, signed_d, err_q, err_d;
  logic [CW-1:0] wdog_q, wdog_d;
  logic op_ok, idle, wd_exp;
  assign op_ok   = op_valid & (op_code <= 3'd5) & ~flush;
  assign idle    = state_q == IDLE;
  assign wd_exp  = wdog_q >= CW'(TIMEOUT - 1);
  assign stall   = op_ok & ~idle;
  assign rd_data = (op_ok & idle & op_code == 3'd2) ? hi_q :
                   (op_ok & idle & op_code == 3'd3) ? lo_q : '0;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = ~idle;
  assign timeout_err = err_q;
  assign mul_signed  = signed_q;
  assign mul_a       = a_q;
  assign mul_b       = b_q;
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    b_d       = b_q;
    signed_d  = signed_q;
    err_d     = err_q;
    wdog_d    = wdog_q;
    mul_start = 1'b0;
    case (state_q)
      IDLE: if (op_ok) begin
        if (op_code <= 3'd1) begin
          a_d      = rs_val;
          b_d      = rt_val;
          signed_d = op_code == 3'd0;
          state_d  = LAUNCH;
        end
        hi_d = op_code == 3'd4 ? rs_val : hi_q;
        lo_d = op_code == 3'd5 ? rs_val : lo_q;
      end
      LAUNCH: if (flush) state_d = IDLE;
        else if (mul_ready) begin
          mul_start = 1'b1;
          wdog_d    = '0;
          state_d   = BUSY;
        end
      BUSY, DRAIN: begin
        wdog_d = wdog_q + 1'b1;
        // a product arriving while draining or alongside a flush is dropped
        if (mul_done) begin
          state_d = IDLE;
          if (state_q == BUSY && !flush) begin
            hi_d = mul_p[2*WIDTH-1:WIDTH];
            lo_d = mul_p[WIDTH-1:0];
          end
        end else if (wd_exp) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (state_q == BUSY && flush) state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      err_q    <= err_d;
      wdog_q   <= wdog_d;
    end
  end
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb_muldiv_hilo_ctrl: scoreboard bench with a 33-cycle iterative multiplier model.
module tb_muldiv_hilo_ctrl;
  localparam int W = 32;
  localparam int LAT = 33;
  logic clk = 0, reset = 0, op_valid = 0, flush = 0, mul_ready, mul_done = 0;
  logic [2:0] op_code = 0;
  logic [W-1:0] rs_val = 0, rt_val = 0;
  logic [2*W-1:0] mul_p = 0;
  logic stall, busy, timeout_err, mul_start, mul_signed;
  logic [W-1:0] rd_data, hi, lo, mul_a, mul_b;
  int total = 0, bad = 0;
  logic [63:0] exp_q[$];
  logic ready_block = 0, withhold = 0;
  int cnt = 0;
  logic [W-1:0] pa = 0, pb = 0;
  logic ps = 0;

  muldiv_hilo_ctrl #(.WIDTH(W), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .stall(stall),
    .rd_data(rd_data), .hi(hi), .lo(lo), .busy(busy), .timeout_err(timeout_err),
    .mul_start(mul_start), .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(mul_ready), .mul_done(mul_done), .mul_p(mul_p));

  always #5 clk = ~clk;

  assign mul_ready = ~ready_block && cnt == 0;
  always @(posedge clk) begin
    mul_done <= 1'b0;
    if (mul_start) begin
      cnt <= LAT; pa <= mul_a; pb <= mul_b; ps <= mul_signed;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1 && !withhold) begin
        mul_done <= 1'b1;
        mul_p <= {{W{ps & pa[W-1]}}, pa} * {{W{ps & pb[W-1]}}, pb};
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    op_valid = 1; op_code = op; rs_val = a; rt_val = b;
    #1 total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL accept_stall got=%b want=0", stall); end
    @(posedge clk); #1;
    op_valid = 0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s_wait busy=%b after %0d cycles", nm, busy, n); end
  endtask

  task automatic check_result(input string nm);
    logic [63:0] e;
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL %s_sb queue empty", nm); end
    else begin
      e = exp_q.pop_front();
      if ({hi, lo} !== e) begin bad++; $display("FAIL %s_hilo got=%h want=%h", nm, {hi, lo}, e); end
    end
  endtask

  task automatic test_reset();
    #2 total++;
    if ({hi, lo, mul_a, mul_b, rd_data} !== '0 || {busy, stall, timeout_err, mul_start, mul_signed} !== 5'b0) begin
      bad++; $display("FAIL reset_vals hi=%h lo=%h busy=%b err=%b start=%b", hi, lo, busy, timeout_err, mul_start);
    end
    repeat (2) @(posedge clk);
    #3 reset = 1;
  endtask

  task automatic test_signed();
    exp_q.push_back(64'(-64'sd16252424673));
    issue(3'd0, 32'd32973, 32'(-492901));
    #1 total++;
    if (mul_start !== 1'b1 || mul_signed !== 1'b1 || mul_a !== 32'd32973) begin
      bad++; $display("FAIL signed_launch start=%b sgn=%b a=%h", mul_start, mul_signed, mul_a);
    end
    @(posedge clk); #1;
    total++;
    if (mul_start !== 1'b0) begin bad++; $display("FAIL signed_start_pulse got=%b want=0", mul_start); end
    op_valid = 1; op_code = 3'd2;
    #1 total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL signed_mfhi_stall got=%b want=1", stall); end
    wait_idle("signed");
    total++;
    if (stall !== 1'b0 || rd_data !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL signed_mfhi got=%h stall=%b want=fffffffc", rd_data, stall);
    end
    check_result("signed");
    op_valid = 0;
  endtask

  task automatic test_unsigned();
    exp_q.push_back(64'd14845119021);
    issue(3'd1, 32'd45621, 32'd325401);
    #1 total++;
    if (mul_start !== 1'b1 || mul_signed !== 1'b0) begin
      bad++; $display("FAIL unsigned_launch start=%b sgn=%b", mul_start, mul_signed);
    end
    wait_idle("unsigned");
    total++;
    if (hi !== 32'd3 || lo !== 32'd1960217133) begin bad++; $display("FAIL unsigned_vals hi=%0d lo=%0d", hi, lo); end
    check_result("unsigned");
  endtask

  task automatic test_back_to_back();
    int n = 0;
    logic [63:0] e = 64'd76282011900;
    exp_q.push_back(e);
    issue(3'd0, 32'(-971436), 32'(-78525));
    op_valid = 1; op_code = 3'd3;
    #1 total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL b2b_stall got=%b want=1", stall); end
    while (stall !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
    total++;
    if (stall !== 1'b0 || busy !== 1'b0 || rd_data !== e[31:0]) begin
      bad++; $display("FAIL b2b_mflo got=%h stall=%b busy=%b want=%h", rd_data, stall, busy, e[31:0]);
    end
    check_result("b2b");
    @(posedge clk); #1 op_valid = 0;
  endtask

  task automatic test_flush();
    int n = 0;
    logic pd;
    @(posedge clk); #1 op_valid = 1; op_code = 3'd4; rs_val = 32'hAAAA;
    @(posedge clk); #1 op_code = 3'd5; rs_val = 32'h5555;
    @(posedge clk); #1 op_valid = 0;
    total++;
    if (hi !== 32'hAAAA || lo !== 32'h5555) begin bad++; $display("FAIL mt_hilo hi=%h lo=%h", hi, lo); end
    issue(3'd0, 32'd7, 32'd9);
    repeat (5) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1 flush = 0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL flush_drain busy=%b want=1", busy); end
    do begin pd = mul_done; @(posedge clk); #1; n++; end while (busy && n < 100);
    total++;
    if (busy !== 1'b0 || pd !== 1'b1) begin bad++; $display("FAIL flush_busy_drop busy=%b prev_done=%b", busy, pd); end
    total++;
    if (hi !== 32'hAAAA || lo !== 32'h5555) begin bad++; $display("FAIL flush_hilo hi=%h lo=%h", hi, lo); end
  endtask

  task automatic test_watchdog();
    ready_block = 1;
    issue(3'd0, 32'd11, 32'd13);
    op_valid = 1; op_code = 3'd2;
    for (int i = 0; i < 4; i++) begin
      #1 total++;
      if (mul_start !== 1'b0 || stall !== 1'b1) begin
        bad++; $display("FAIL bp_hold%0d start=%b stall=%b", i, mul_start, stall);
      end
      @(posedge clk); #1;
    end
    op_valid = 0; withhold = 1; ready_block = 0;
    #1 total++;
    if (mul_start !== 1'b1) begin bad++; $display("FAIL bp_start got=%b want=1", mul_start); end
    repeat (64) @(posedge clk);
    #1 total++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL wd_early err=%b busy=%b", timeout_err, busy); end
    @(posedge clk); #1;
    total++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL wd_expire err=%b busy=%b", timeout_err, busy); end
    total++;
    if (hi !== 32'hAAAA || lo !== 32'h5555) begin bad++; $display("FAIL wd_hilo hi=%h lo=%h", hi, lo); end
    withhold = 0;
  endtask

  task automatic test_async_reset();
    issue(3'd0, 32'd3, 32'd5);
    repeat (3) @(posedge clk);
    #3 reset = 0;
    #1 total++;
    if ({hi, lo, mul_a, mul_b} !== '0 || {busy, timeout_err, mul_start, mul_signed} !== 4'b0) begin
      bad++; $display("FAIL rst_mid hi=%h lo=%h busy=%b err=%b a=%h", hi, lo, busy, timeout_err, mul_a);
    end
    @(posedge clk); #3 reset = 1;
    @(posedge clk); #1 op_valid = 1; op_code = 3'd2;
    #1 total++;
    if (rd_data !== '0 || stall !== 1'b0) begin bad++; $display("FAIL rst_mfhi got=%h stall=%b want=0", rd_data, stall); end
    op_valid = 0;
    repeat (40) @(posedge clk);
    #1 total++;
    if (hi !== '0 || lo !== '0 || busy !== 1'b0) begin bad++; $display("FAIL late_done hi=%h lo=%h busy=%b", hi, lo, busy); end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_back_to_back();
    test_flush();
    test_watchdog();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
